// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared encodings for the multicycle ARMv4 control unit: state enum, ALU codes,
// instruction-field constants and datapath select values.
package multicycle_ctrl_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCB_RM   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_fsm_alu_decoder.sv
// Data-processing ALU decoder: Funct[4:0] -> ALUControl/FlagW, enabled by the FSM.
// CTRL_NOWRITE_EN adds CMP (SUB, flags only) and flags it as a no-writeback op.
module multicycle_ctrl_fsm_alu_decoder
  import multicycle_ctrl_fsm_pkg::*;
(
  input  logic       en,
  input  logic [4:0] funct,
  output logic [1:0] alu_control,
  output logic [1:0] flag_w,
  output logic       no_write
);

  logic [3:0] cmd;
  logic       s_bit;

  assign cmd   = funct[4:1];
  assign s_bit = funct[0];

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    alu_control = ALU_ADD;
    flag_w      = 2'b00;
    no_write    = 1'b0;
    if (en) begin
      case (cmd)
        CMD_ADD: alu_control = ALU_ADD;
        CMD_SUB: alu_control = ALU_SUB;
        CMD_AND: alu_control = ALU_AND;
        CMD_ORR: alu_control = ALU_ORR;
`ifdef CTRL_NOWRITE_EN
        CMD_CMP: begin
          alu_control = ALU_SUB;
          no_write    = 1'b1;
        end
`endif
        default: alu_control = ALU_ADD;
      endcase

      // C,V only make sense for arithmetic results.
      flag_w[1] = s_bit;
      flag_w[0] = s_bit & ((alu_control == ALU_ADD) | (alu_control == ALU_SUB));
`ifdef CTRL_NOWRITE_EN
      if (cmd == CMD_CMP) flag_w = 2'b11;
`endif
    end
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Moore control FSM for the multicycle ARMv4 datapath: drives mux selects and
// unconditioned write intents. CTRL_NOWRITE_EN lets CMP skip ALUWB.
module multicycle_ctrl_fsm
  import multicycle_ctrl_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic       PCS,
  output logic       RegW,
  output logic       MemW,
  output logic [1:0] FlagW,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUControl,
  output logic [3:0] state_o
);

  state_t     state, state_next;
  logic       alu_en;
  logic       no_write;
  logic [1:0] alu_ctrl;
  logic [1:0] flag_w;

  assign alu_en = (state == S_EXECUTER) || (state == S_EXECUTEI);

  multicycle_ctrl_fsm_alu_decoder u_alu_dec (
    .en          (alu_en),
    .funct       (Funct[4:0]),
    .alu_control (alu_ctrl),
    .flag_w      (flag_w),
    .no_write    (no_write)
  );

  // NOTE: state is sequential, so it is updated with non-blocking assignment only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_FETCH;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_MEM:  state_next = S_MEMADR;
          OP_DP:   state_next = Funct[5] ? S_EXECUTEI : S_EXECUTER;
          OP_BR:   state_next = S_BRANCH;
          default: state_next = S_FETCH;
        endcase
      end
      S_MEMADR:   state_next = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:    state_next = S_MEMWB;
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWR:    state_next = S_FETCH;
      S_EXECUTER,
      S_EXECUTEI: state_next = no_write ? S_FETCH : S_ALUWB;
      S_ALUWB:    state_next = S_FETCH;
      S_BRANCH:   state_next = S_FETCH;
      default:    state_next = S_FETCH;
    endcase
  end

  always_comb begin
    PCS        = 1'b0;
    RegW       = 1'b0;
    MemW       = 1'b0;
    IRWrite    = 1'b0;
    NextPC     = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_RM;
    ALUControl = alu_ctrl;
    FlagW      = flag_w;

    case (state)
      S_FETCH: begin
        IRWrite   = 1'b1;
        NextPC    = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
      end
      S_EXECUTER: ALUSrcB = SRCB_RM;
      S_EXECUTEI: ALUSrcB = SRCB_IMM;
      S_ALUWB: begin
        ResultSrc = RES_ALUOUT;
        RegW      = 1'b1;
        PCS       = (Rd == 4'hF);
      end
      S_MEMADR: ALUSrcB = SRCB_IMM;
      S_MEMRD:  AdrSrc  = 1'b1;
      S_MEMWB: begin
        ResultSrc = RES_RDATA;
        RegW      = 1'b1;
        PCS       = (Rd == 4'hF);
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALU;
        PCS       = 1'b1;
      end
      default: ;
    endcase

    // State is already FETCH under reset; only the write intents need masking.
    if (!rst) begin
      PCS     = 1'b0;
      RegW    = 1'b0;
      MemW    = 1'b0;
      IRWrite = 1'b0;
      NextPC  = 1'b0;
      FlagW   = 2'b00;
    end
  end

  assign state_o = state;

endmodule
